// File: rtl/video_capture_scaler.sv
// Frame-synchronous video capture with integer horizontal/vertical decimation.
// Kept pixels are written as RGB888 or RGB332 words to a linear frame store.
module video_capture_scaler #(
   parameter int unsigned H_DEC  = 4,
   parameter int unsigned V_DEC  = 4,
   parameter int unsigned ADDR_W = 17,
   parameter int unsigned DEPTH  = 76800,
   parameter bit          VS_POL = 1'b1
) (
   input  logic              pclk,
   input  logic              rstb,
   input  logic [23:0]       pdata,
   input  logic              vde,
   input  logic              vsync,
   input  logic              capture_en,
   input  logic              mode,
   output logic              we,
   output logic [ADDR_W-1:0] waddr,
   output logic [23:0]       wdata,
   output logic              start_frame,
   output logic              overflow,
   output logic [15:0]       frame_cnt
);

   typedef enum logic [1:0] {StIdle, StArmed, StCapture} state_e;

   state_e            state_q;
   logic [1:0]        rst_sync_q;
   logic              rst_sync_n;
   logic              vs_q;
   logic              vde_q;
   logic [4:0]        col_q;
   logic [4:0]        row_q;
   logic              mode_q;
   logic [ADDR_W:0]   wptr_q;
   logic              we_q;
   logic [ADDR_W-1:0] waddr_q;
   logic [23:0]       wdata_q;
   logic              start_q;
   logic              ovf_q;
   logic [15:0]       frame_cnt_q;

   logic              frame_edge;
   logic              vde_rise;
   logic              vde_fall;
   logic [4:0]        col_cur;
   logic              keep;
   logic              room;
   logic [23:0]       pix_fmt;

   // Assert asynchronously, release two pclk edges after rstb rises.
   always_ff @(posedge pclk or negedge rstb) begin
      if (!rstb) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign rst_sync_n = rst_sync_q[1];

   always_comb begin
      frame_edge = (vsync == VS_POL) && (vs_q != VS_POL);
      vde_rise   = vde && !vde_q;
      vde_fall   = !vde && vde_q;
      col_cur    = vde_rise ? 5'd0 : col_q;
      keep       = vde && (col_cur == 5'd0) && (row_q == 5'd0) &&
                   (state_q == StCapture) && !frame_edge;
      room       = wptr_q < (ADDR_W + 1)'(DEPTH);
      pix_fmt    = mode_q ? {16'h0, pdata[23:21], pdata[15:13], pdata[7:6]} : pdata;
   end

   always_ff @(posedge pclk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         state_q     <= StIdle;
         vs_q        <= 1'b0;
         vde_q       <= 1'b0;
         col_q       <= 5'd0;
         row_q       <= 5'd0;
         mode_q      <= 1'b0;
         wptr_q      <= '0;
         we_q        <= 1'b0;
         waddr_q     <= '0;
         wdata_q     <= 24'h0;
         start_q     <= 1'b0;
         ovf_q       <= 1'b0;
         frame_cnt_q <= 16'h0;
      end else begin
         vs_q    <= vsync;
         vde_q   <= vde;
         we_q    <= 1'b0;
         start_q <= 1'b0;
         if (vde) begin
            col_q <= (col_cur == 5'(H_DEC - 1)) ? 5'd0 : col_cur + 5'd1;
         end
         if (vde_fall) begin
            row_q <= (row_q == 5'(V_DEC - 1)) ? 5'd0 : row_q + 5'd1;
         end
         case (state_q)
            StIdle: begin
               if (capture_en) begin
                  state_q <= StArmed;
               end
            end
            StArmed: begin
               if (!capture_en) begin
                  state_q <= StIdle;
               end else if (frame_edge) begin
                  state_q <= StCapture;
                  start_q <= 1'b1;
                  waddr_q <= '0;
                  wptr_q  <= '0;
                  ovf_q   <= 1'b0;
                  row_q   <= 5'd0;
                  mode_q  <= mode;
               end
            end
            StCapture: begin
               if (frame_edge) begin
                  frame_cnt_q <= frame_cnt_q + 16'd1;
                  if (capture_en) begin
                     start_q <= 1'b1;
                     waddr_q <= '0;
                     wptr_q  <= '0;
                     ovf_q   <= 1'b0;
                     row_q   <= 5'd0;
                     mode_q  <= mode;
                  end else begin
                     state_q <= StIdle;
                  end
               end else if (keep) begin
                  // Past DEPTH writes the address freezes at the last written word.
                  if (room) begin
                     we_q    <= 1'b1;
                     waddr_q <= wptr_q[ADDR_W-1:0];
                     wdata_q <= pix_fmt;
                     wptr_q  <= wptr_q + (ADDR_W + 1)'(1);
                  end else begin
                     ovf_q <= 1'b1;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign we          = we_q;
   assign waddr       = waddr_q;
   assign wdata       = wdata_q;
   assign start_frame = start_q;
   assign overflow    = ovf_q;
   assign frame_cnt   = frame_cnt_q;

endmodule
